// File: rtl/safe_entry_ctrl_pkg.sv
// Shared constants for the safe keypad controller: display-mode encodings, FSM state
// encodings, the default passcode and a state-to-display decode helper.
package safe_entry_ctrl_pkg;

  localparam logic [2:0] DISP_ERR   = 3'b001;
  localparam logic [2:0] DISP_CODE  = 3'b010;
  localparam logic [2:0] DISP_BLANK = 3'b100;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StEntry   = 3'd1;
  localparam logic [2:0] StError   = 3'd2;
  localparam logic [2:0] StLockout = 3'd3;
  localparam logic [2:0] StOpen    = 3'd4;

  localparam logic [15:0] PASSCODE_DEFAULT = 16'h9070;

  function automatic logic [2:0] disp_for_state(input logic [2:0] st);
    logic [2:0] disp;
    case (st)
      StEntry, StOpen:    disp = DISP_CODE;
      StError, StLockout: disp = DISP_ERR;
      default:            disp = DISP_BLANK;
    endcase
    return disp;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter shared by the timed ERROR, LOCKOUT and OPEN phases.
// Holds at zero; expired is high whenever the count is zero.
module dwell_timer #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             expired
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/safe_entry_ctrl.sv
// Keypad-entry controller and lock FSM: assembles a 4-digit BCD code, checks it on ENTER,
// runs timed Err/lockout phases. Optional auto-relock of OPEN under `SAFE_AUTO_RELOCK_EN.
module safe_entry_ctrl
  import safe_entry_ctrl_pkg::*;
#(
  parameter logic [15:0] PASSCODE       = PASSCODE_DEFAULT,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned ERR_CYCLES     = 8,
  parameter int unsigned LOCKOUT_CYCLES = 32,
  parameter int unsigned RELOCK_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_enter,
  input  logic        key_clear,
  output logic [15:0] entered_code,
  output logic [2:0]  display_mode,
  output logic        unlocked,
  output logic        locked_out,
  output logic [2:0]  fail_count
);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

`ifdef SAFE_AUTO_RELOCK_EN
  localparam int unsigned MaxCycles = max_u(max_u(ERR_CYCLES, LOCKOUT_CYCLES), RELOCK_CYCLES);
`else
  localparam int unsigned MaxCycles = max_u(ERR_CYCLES, LOCKOUT_CYCLES);
`endif
  localparam int unsigned TimerWidth = $clog2(MaxCycles) + 1;

  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 7 || ERR_CYCLES < 1 || LOCKOUT_CYCLES < 1 ||
      RELOCK_CYCLES < 1) begin : g_param_check
    $error("safe_entry_ctrl: parameter out of range");
  end

  logic [2:0]            state_q, state_d;
  logic [15:0]           code_q, code_d;
  logic [2:0]            digits_q, digits_d;
  logic [2:0]            fail_q, fail_d;
  logic [2:0]            fail_inc;
  logic [2:0]            disp_q;
  logic                  unlocked_q, locked_out_q;
  logic                  digit_ok;
  logic                  tmr_load;
  logic [TimerWidth-1:0] tmr_value;
  logic                  tmr_expired;

  dwell_timer #(
    .Width(TimerWidth)
  ) u_dwell_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tmr_load),
    .load_value(tmr_value),
    .expired   (tmr_expired)
  );

  assign digit_ok = key_valid && (key_digit <= 4'd9);
  assign fail_inc = fail_q + 3'd1;

  // Strobe priority inside IDLE/ENTRY: clear, then enter, then digit.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    digits_d = digits_q;
    fail_d   = fail_q;
    case (state_q)
      StIdle, StEntry: begin
        if (key_clear) begin
          state_d = StIdle;
        end else if (key_enter) begin
          if (digits_q == 3'd4 && code_q == PASSCODE) begin
            state_d = StOpen;
            fail_d  = 3'd0;
          end else begin
            fail_d  = fail_inc;
            state_d = (fail_inc == 3'(MAX_ATTEMPTS)) ? StLockout : StError;
          end
        end else if (digit_ok && digits_q < 3'd4) begin
          code_d   = {code_q[11:0], key_digit};
          digits_d = digits_q + 3'd1;
          state_d  = StEntry;
        end
      end
      StError: begin
        if (tmr_expired) state_d = StIdle;
      end
      StLockout: begin
        if (tmr_expired) begin
          state_d = StIdle;
          fail_d  = 3'd0;
        end
      end
      StOpen: begin
        if (key_clear) begin
          state_d = StIdle;
`ifdef SAFE_AUTO_RELOCK_EN
        end else if (tmr_expired) begin
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) begin
      code_d   = 16'h0000;
      digits_d = 3'd0;
    end
  end

  // Timer is loaded with N-1 on phase entry so the phase lasts exactly N cycles.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    if (state_d != state_q) begin
      case (state_d)
        StError: begin
          tmr_load  = 1'b1;
          tmr_value = TimerWidth'(ERR_CYCLES - 1);
        end
        StLockout: begin
          tmr_load  = 1'b1;
          tmr_value = TimerWidth'(LOCKOUT_CYCLES - 1);
        end
`ifdef SAFE_AUTO_RELOCK_EN
        StOpen: begin
          tmr_load  = 1'b1;
          tmr_value = TimerWidth'(RELOCK_CYCLES - 1);
        end
`endif
        default: tmr_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      code_q       <= 16'h0000;
      digits_q     <= 3'd0;
      fail_q       <= 3'd0;
      disp_q       <= DISP_BLANK;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      digits_q     <= digits_d;
      fail_q       <= fail_d;
      disp_q       <= disp_for_state(state_d);
      unlocked_q   <= (state_d == StOpen);
      locked_out_q <= (state_d == StLockout);
    end
  end

  assign entered_code = code_q;
  assign display_mode = disp_q;
  assign unlocked     = unlocked_q;
  assign locked_out   = locked_out_q;
  assign fail_count   = fail_q;

endmodule

// File: doc/safe_entry_ctrl.md
# safe_entry_ctrl

Keypad-entry controller and lock FSM for the digital safe, sitting directly upstream of the display multiplexer. Accepts debounced single-cycle key strobes, assembles a 4-digit BCD code, compares it against the configured passcode on ENTER, tracks failed attempts with timed error and lockout phases, and drives the `entered_code` / `display_mode` pair the display mux consumes.

## Interface
- `PASSCODE`, 16'h9070: 4 BCD digits; the most significant nibble is the first digit entered.
- `MAX_ATTEMPTS`, 3: consecutive failures that trigger lockout, range 1..7.
- `ERR_CYCLES`, 8: number of cycles Err is shown after a failed attempt, minimum 1.
- `LOCKOUT_CYCLES`, 32: length of the lockout, in cycles, minimum 1.
- `RELOCK_CYCLES`, 64: cycles before auto-relock. Used only with `AUTO_RELOCK_EN`.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `key_valid`  in  1  one-cycle strobe: `key_digit` is valid.
- `key_digit`  in  4  BCD digit. Values above 9 are ignored.
- `key_enter`  in  1  one-cycle strobe: submit the code.
- `key_clear`  in  1  one-cycle strobe: discard entry, or relock while open.
- `entered_code`  out  16  digits entered so far, right-aligned.
- `display_mode`  out  3  one-hot: 3'b001 Err, 3'b010 show code, 3'b100 blank.
- `unlocked`  out  1  high while in OPEN.
- `locked_out`  out  1  high while in LOCKOUT.
- `fail_count`  out  3  consecutive failed attempts.

## Operation
- States and `display_mode` per state: IDLE is blank, ENTRY shows the code, ERROR shows Err, LOCKOUT shows Err, OPEN shows the code.
- Input priority when strobes coincide: `key_clear`, then `key_enter`, then `key_valid`. Only the highest-priority strobe acts.
- Valid digit in IDLE or ENTRY:
  - If fewer than 4 digits are held, `entered_code <= {entered_code[11:0], key_digit}`, the digit count increments, and state becomes ENTRY.
  - A 5th or later digit is ignored.
  - A digit above 9 is ignored in every state.
- ENTER in ENTRY:
  - Match requires count == 4 and `entered_code == PASSCODE`. On a match the next state is OPEN and `fail_count` clears.
  - Otherwise `fail_count` increments. If the new count equals `MAX_ATTEMPTS`, go to LOCKOUT; else go to ERROR.
- ENTER in IDLE (zero digits) counts as a failed attempt, the same as a mismatch.
- CLEAR in ENTRY: return to IDLE with the code and count zeroed. `fail_count` is unchanged.
- CLEAR in OPEN: return to IDLE, deassert `unlocked`, and zero the code.
- ERROR and LOCKOUT ignore all key strobes.
- When the ERROR timer expires, go to IDLE with the code zeroed. `fail_count` is retained.
- When the LOCKOUT timer expires, go to IDLE with the code zeroed and `fail_count` cleared to 0.
- OPEN ignores digits and ENTER.
- `entered_code` holds its value in ERROR, LOCKOUT and OPEN. It is zeroed whenever IDLE is entered.

## Timing
- All outputs are registered. A strobe sampled at edge N is reflected on the outputs after edge N, with 1-cycle latency.
- Reset values while `rst_n` is low, taking effect immediately and asynchronously:
  - state IDLE, `entered_code` 16'h0000, `display_mode` 3'b100
  - `unlocked` 0, `locked_out` 0, `fail_count` 0, digit count 0, timer 0.
- ERROR: `display_mode` is 3'b001 for exactly `ERR_CYCLES` cycles, then 3'b100 on the next cycle.
- LOCKOUT: `locked_out` and Err are asserted for exactly `LOCKOUT_CYCLES` cycles.
- Reset asserted mid-ERROR, mid-LOCKOUT or mid-OPEN aborts the phase. There is no residual lockout and no residual unlock.
- The timer is loaded on state entry and is never free-running. Its width is `$clog2` of the largest used cycle parameter, plus 1.

## Configuration
- `SAFE_AUTO_RELOCK_EN` defined: OPEN returns to IDLE automatically after `RELOCK_CYCLES` cycles unless `key_clear` arrives first. `unlocked` is high for exactly `RELOCK_CYCLES` cycles.
- `SAFE_AUTO_RELOCK_EN` undefined: OPEN persists until `key_clear` or reset. `RELOCK_CYCLES` is unused.

## Structure
- The team params header holds:
  - the display-mode encodings `DISP_ERR` = 3'b001, `DISP_CODE` = 3'b010, `DISP_BLANK` = 3'b100;
  - the state encodings;
  - the `PASSCODE` default.
- `display_mux` uses the same display-mode constants.
- One sub-module, `dwell_timer`: a loadable down-counter with `load`, `load_value` and an `expired` flag. It is shared by ERROR, LOCKOUT and OPEN, since only one of these is active at a time.

## Test plan
- **Reset:** hold `rst_n` low with key activity present → all outputs at their reset values, `display_mode` 3'b100.
- **Correct code:** digits 9, 0, 7, 0 then ENTER → `entered_code` steps 0009, 0090, 0907, 9070 with `display_mode` 010; then `unlocked` = 1 and `fail_count` = 0.
- **Wrong code:** digits 1, 2, 3, 4 then ENTER → Err (001) for 8 cycles, then blank, `entered_code` 0000, `fail_count` 1. Keys pressed during Err have no effect.
- **Lockout:** three wrong entries → on the third, `locked_out` = 1 for 32 cycles, then IDLE with `fail_count` 0.
- **Edge input:** 5 digits (9, 0, 7, 0, 5) ignore the 5th; a digit 4'hA is ignored; ENTER after 3 digits fails; `key_clear` together with `key_enter` clears only.
- **Relock:** with `SAFE_AUTO_RELOCK_EN`, `unlocked` drops after 64 cycles. Without it, `unlocked` stays high for 200 cycles until `key_clear`.
